adder_gf2_join_acc: RTL

N-lane GF(2) adder with per-lane valid/ready join, optional frame XOR-accumulate mode and a 2-entry output skid buffer.
- Mode 0: XORs one beat from every input lane and emits one sum per beat.
- Mode 1: XOR-reduces all beats of a frame, delimited by i_in_last, and emits one sum per frame together with its beat count.
- Successor to the two-operand GF(2) adder; sits between parity/syndrome producers and downstream stream consumers.

---
 rtl/adder_gf2_join_acc.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/adder_gf2_join_acc.sv
// adder_gf2_join_acc
//   N-lane GF(2) adder. A beat is taken only when every lane is valid at the
//   same time, and then all lanes are consumed together. The beat value is the
//   XOR of all lane words.
//   Mode 0 emits one sum per beat. Mode 1 XOR-accumulates the beats of a frame
//   that ends with i_in_last, and emits one sum per frame together with its
//   beat count. Results pass through a 2-entry FIFO with registered outputs.
//
// Ports
//   i_clock      : clock; all logic updates on the rising edge
//   i_reset_n    : asynchronous active-low reset; release is synchronised inside
//   i_in_data    : NUM_IN lanes; lane k is at [k*WIDTH +: WIDTH]
//   i_in_valid   : per-lane valid
//   o_in_ready   : per-lane ready; the same value on every lane
//   i_in_last    : frame end marker, sampled with each accepted beat
//   i_mode       : 0 = per-beat sum, 1 = frame accumulate (sampled on the first beat)
//   o_sum_data   : XOR result
//   o_sum_count  : number of beats that contributed to o_sum_data
//   o_sum_valid  : output valid
//   i_sum_ready  : output ready
module adder_gf2_join_acc #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 3,
  parameter int CNT_W  = 16
) (
  input  logic                    i_clock,
  input  logic                    i_reset_n,
  input  logic [NUM_IN*WIDTH-1:0] i_in_data,
  input  logic [NUM_IN-1:0]       i_in_valid,
  output logic [NUM_IN-1:0]       o_in_ready,
  input  logic                    i_in_last,
  input  logic                    i_mode,
  output logic [WIDTH-1:0]        o_sum_data,
  output logic [CNT_W-1:0]        o_sum_count,
  output logic                    o_sum_valid,
  input  logic                    i_sum_ready
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {ST_IDLE, ST_ACCUM} state_t;

  // Reset asserts at once and releases two edges later, in step with i_clock.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_rst_sync <= 2'b00;
    else            r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  // Frame state
  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_acc, w_acc_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  // Output FIFO: r_head drives the outputs, r_tail holds the second entry
  logic [WIDTH-1:0] r_head_data, r_tail_data;
  logic [CNT_W-1:0] r_head_cnt, r_tail_cnt;
  logic [1:0]       r_occ;

  logic [WIDTH-1:0] w_beat;
  logic [WIDTH-1:0] w_acc_sum;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_can_accept;
  logic             w_accept;
  logic             w_pop;
  logic             w_push;
  logic [WIDTH-1:0] w_push_data;
  logic [CNT_W-1:0] w_push_cnt;

  always_comb begin
    w_beat = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      w_beat = w_beat ^ i_in_data[k*WIDTH +: WIDTH];
    end
  end

  // A full FIFO blocks input even when the head is popped in the same cycle.
  // This keeps ready independent of i_sum_ready.
  assign w_can_accept = w_rst_n & (r_occ != 2'd2);
  assign w_accept     = w_can_accept & (&i_in_valid);
  assign o_in_ready   = {NUM_IN{w_accept}};
  assign w_pop        = (r_occ != 2'd0) & i_sum_ready;

  assign w_acc_sum = r_acc ^ w_beat;
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_push      = 1'b0;
    w_push_data = w_beat;
    w_push_cnt  = CNT_ONE;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (!i_mode || i_in_last) begin
            w_push = 1'b1;
          end else begin
            w_acc_nxt   = w_beat;
            w_cnt_nxt   = CNT_ONE;
            w_state_nxt = ST_ACCUM;
          end
        end
      end
      ST_ACCUM: begin
        if (w_accept) begin
          if (i_in_last) begin
            w_push      = 1'b1;
            w_push_data = w_acc_sum;
            w_push_cnt  = w_cnt_inc;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_acc_nxt = w_acc_sum;
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Output FIFO. At occupancy 1, a push together with a pop replaces the head.
  always_ff @(posedge i_clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_occ       <= 2'd0;
      r_head_data <= '0;
      r_head_cnt  <= '0;
      r_tail_data <= '0;
      r_tail_cnt  <= '0;
    end else begin
      unique case (r_occ)
        2'd0: begin
          if (w_push) begin
            r_head_data <= w_push_data;
            r_head_cnt  <= w_push_cnt;
            r_occ       <= 2'd1;
          end
        end
        2'd1: begin
          if (w_push && w_pop) begin
            r_head_data <= w_push_data;
            r_head_cnt  <= w_push_cnt;
          end else if (w_push) begin
            r_tail_data <= w_push_data;
            r_tail_cnt  <= w_push_cnt;
            r_occ       <= 2'd2;
          end else if (w_pop) begin
            r_occ <= 2'd0;
          end
        end
        2'd2: begin
          if (w_pop) begin
            r_head_data <= r_tail_data;
            r_head_cnt  <= r_tail_cnt;
            r_occ       <= 2'd1;
          end
        end
        default: r_occ <= 2'd0;
      endcase
    end
  end

  assign o_sum_data  = r_head_data;
  assign o_sum_count = r_head_cnt;
  assign o_sum_valid = (r_occ != 2'd0);

endmodule
